// File: rtl/vga_timing_pkg.sv
// Shared raster timing defaults (640x480@60) and helpers used by the timing
// generator and the text/bitmap controllers.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_PIPE_LAT = 2;
    localparam int DEF_CW       = 10;
    localparam int DEF_FCW      = 8;

    // One display-side sample; hs/vs hold the final pin levels, not raw terms.
    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
    } disp_t;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: pixel enable in, fetch-side and display-side timing out.
interface vga_timing_gen_if
    import vga_timing_pkg::*;
#(
    parameter int CW  = DEF_CW,
    parameter int FCW = DEF_FCW
);
    logic           en;
    logic [CW-1:0]  posx;
    logic [CW-1:0]  posy;
    logic           fetch_de;
    logic           line_start;
    logic           frame_start;
    logic           de_o;
    logic           h_sync_o;
    logic           v_sync_o;
    logic           vblank_irq;
    logic [FCW-1:0] frame_cnt;

    modport master (
        input  en,
        output posx, posy, fetch_de, line_start, frame_start,
        output de_o, h_sync_o, v_sync_o, vblank_irq, frame_cnt
    );

    modport slave (
        output en,
        input  posx, posy, fetch_de, line_start, frame_start,
        input  de_o, h_sync_o, v_sync_o, vblank_irq, frame_cnt
    );

endinterface

// File: rtl/delay_line.sv
// Clock-enabled shift register that resets every stage to a constant; also
// intended for aligning pixel data with the delayed timing.
module delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stages [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= RESET_VAL;
            end
        end else if (en) begin
            stages[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign dout = stages[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: fetch-side coordinates one cycle after
// the counters, display-side sync/de a further PIPE_LAT enabled cycles later.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int PIPE_LAT   = DEF_PIPE_LAT,
    parameter int CW         = DEF_CW,
    parameter int FCW        = DEF_FCW
) (
    input  logic             clk,
    input  logic             rst_n,
    vga_timing_gen_if.master bus
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEGIN = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEGIN = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

    localparam disp_t DISP_IDLE = '{de: 1'b0, hs: ~H_SYNC_POL, vs: ~V_SYNC_POL};

    logic [CW-1:0]  h_cnt;
    logic [CW-1:0]  v_cnt;
    logic [CW-1:0]  posx_q;
    logic [CW-1:0]  posy_q;
    logic           line_start_q;
    logic           frame_start_q;
    disp_t          fetch_disp;
    disp_t          disp;
    logic           vb_now;
    logic           vb_pre;
    logic           vblank_q;
    logic [FCW-1:0] frame_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (bus.en) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CW'(1);
            end else begin
                h_cnt <= h_cnt + CW'(1);
            end
        end
    end

    // Strobes are re-evaluated every clock so a stall clears them instead of
    // holding them, while the coordinate and timing registers freeze.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            posx_q        <= '0;
            posy_q        <= '0;
            fetch_disp    <= DISP_IDLE;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            line_start_q  <= bus.en && (h_cnt == '0);
            frame_start_q <= bus.en && (h_cnt == '0) && (v_cnt == '0);
            if (bus.en) begin
                posx_q        <= h_cnt;
                posy_q        <= v_cnt;
                fetch_disp.de <= (h_cnt < H_ACT) && (v_cnt < V_ACT);
                fetch_disp.hs <= ((h_cnt >= HS_BEGIN) && (h_cnt < HS_END)) ? H_SYNC_POL : ~H_SYNC_POL;
                fetch_disp.vs <= ((v_cnt >= VS_BEGIN) && (v_cnt < VS_END)) ? V_SYNC_POL : ~V_SYNC_POL;
            end
        end
    end

    assign vb_now = (h_cnt == '0) && (v_cnt == V_ACT);

    generate
        if (PIPE_LAT == 0) begin : g_no_pipe
            assign disp = fetch_disp;
        end else begin : g_pipe
            delay_line #(
                .WIDTH     ($bits(disp_t)),
                .DEPTH     (PIPE_LAT),
                .RESET_VAL (DISP_IDLE)
            ) u_disp_delay (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (bus.en),
                .din   (fetch_disp),
                .dout  (disp)
            );
        end
    endgenerate

    // vb_pre is the vblank term one stage before the display register, so the
    // irq register can gate it with en and fire exactly once per event.
    generate
        if (PIPE_LAT == 0) begin : g_vb_direct
            assign vb_pre = vb_now;
        end else begin : g_vb_pipe
            logic vb_term;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vb_term <= 1'b0;
                end else if (bus.en) begin
                    vb_term <= vb_now;
                end
            end

            if (PIPE_LAT == 1) begin : g_vb_one
                assign vb_pre = vb_term;
            end else begin : g_vb_deep
                delay_line #(
                    .WIDTH     (1),
                    .DEPTH     (PIPE_LAT - 1),
                    .RESET_VAL (1'b0)
                ) u_vb_delay (
                    .clk   (clk),
                    .rst_n (rst_n),
                    .en    (bus.en),
                    .din   (vb_term),
                    .dout  (vb_pre)
                );
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vblank_q    <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            vblank_q <= bus.en && vb_pre;
            if (bus.en && vb_pre) begin
                frame_cnt_q <= frame_cnt_q + FCW'(1);
            end
        end
    end

    assign bus.posx        = posx_q;
    assign bus.posy        = posy_q;
    assign bus.fetch_de    = fetch_disp.de;
    assign bus.line_start  = line_start_q;
    assign bus.frame_start = frame_start_q;
    assign bus.de_o        = disp.de;
    assign bus.h_sync_o    = disp.hs;
    assign bus.v_sync_o    = disp.vs;
    assign bus.vblank_irq  = vblank_q;
    assign bus.frame_cnt   = frame_cnt_q;

endmodule
